// File: rtl/lcd_hd44780_responder.sv
// rtl/lcd_hd44780_responder.sv - HD44780-style 8-bit LCD bus responder with 16x2 character buffer
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       lcd_RS,
  input  logic       lcd_RW,
  input  logic       lcd_E,
  inout  wire  [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY} state_t;

  localparam logic [16:0] BUSY_LD     = 17'(BUSY_CYCLES);
  localparam logic [16:0] CLR_LD      = 17'(CLEAR_CYCLES);
  localparam logic [16:0] CLR_REM     = (CLEAR_CYCLES > 32) ? 17'(CLEAR_CYCLES - 32) : 17'd0;
  localparam logic        CLR_TO_IDLE = (CLEAR_CYCLES <= 32);

  state_t      r_state, w_state_nxt;
  logic [16:0] r_cnt, w_cnt_nxt;
  logic [4:0]  r_fill, w_fill_nxt;
  logic [6:0]  r_ac, w_ac_nxt;
  logic        r_id, w_id_nxt;
  logic [2:0]  r_dcb, w_dcb_nxt;
  logic        r_ovr, w_ovr_nxt;
  logic        r_drive;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_rd_char;
  logic [7:0]  r_buf [32];

  logic        r_e_s1, r_e_s2, r_e_d;
  logic        r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
  logic [7:0]  r_d_s1, r_d_s2;

  logic        w_rise, w_fall, w_wr, w_rdfall, w_busy, w_we;
  logic [4:0]  w_idx, w_waddr;
  logic [7:0]  w_wdata;

  // Address counter stepping with the line-wrap behaviour of a 2-line DDRAM map
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] res;
    if (inc) begin
      if (ac == 7'h0F)      res = 7'h40;
      else if (ac == 7'h4F) res = 7'h00;
      else                  res = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      res = 7'h4F;
      else if (ac == 7'h40) res = 7'h0F;
      else                  res = ac - 7'd1;
    end
    return res;
  endfunction

  assign w_rise   = r_e_s2 & ~r_e_d;
  assign w_fall   = ~r_e_s2 & r_e_d;
  assign w_wr     = w_fall & ~r_rw_s2;
  assign w_rdfall = w_fall & r_rw_s2;
  assign w_idx    = {r_ac[6], r_ac[3:0]};
  assign w_busy   = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fill_nxt  = r_fill;
    w_ac_nxt    = r_ac;
    w_id_nxt    = r_id;
    w_dcb_nxt   = r_dcb;
    w_ovr_nxt   = r_ovr;
    w_we        = 1'b0;
    w_waddr     = w_idx;
    w_wdata     = r_d_s2;
    if (w_rdfall && r_rs_s2) w_ac_nxt = ac_step(r_ac, r_id);
    if (w_wr && w_busy) w_ovr_nxt = 1'b1;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_fill;
        w_wdata = 8'h20;
        if (r_fill == 5'd31) begin
          w_state_nxt = CLR_TO_IDLE ? S_IDLE : S_BUSY;
          w_cnt_nxt   = CLR_REM;
        end else begin
          w_fill_nxt = r_fill + 5'd1;
        end
      end
      S_IDLE: begin
        if (w_wr) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = BUSY_LD;
          if (r_rs_s2) begin
            w_we     = 1'b1;
            w_ac_nxt = ac_step(r_ac, r_id);
          end else begin
            casez (r_d_s2)
              8'b1???????: w_ac_nxt = {r_d_s2[6], 2'b00, r_d_s2[3:0]};
              8'b01??????, 8'b001?????, 8'b0001????: begin end
              8'b00001???: w_dcb_nxt = r_d_s2[2:0];
              8'b000001??: w_id_nxt = r_d_s2[1];
              8'b0000001?: begin
                w_ac_nxt  = 7'h00;
                w_cnt_nxt = CLR_LD;
              end
              8'b00000001: begin
                w_state_nxt = S_CLEAR;
                w_fill_nxt  = 5'd0;
                w_ac_nxt    = 7'h00;
                w_id_nxt    = 1'b1;
              end
              default: begin end
            endcase
          end
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 17'd1;
        if (r_cnt <= 17'd1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state   <= S_CLEAR;
      r_cnt     <= 17'd0;
      r_fill    <= 5'd0;
      r_ac      <= 7'h00;
      r_id      <= 1'b1;
      r_dcb     <= 3'b000;
      r_ovr     <= 1'b0;
      r_drive   <= 1'b0;
      r_rd_data <= 8'h00;
      r_rd_char <= 8'h00;
      r_e_s1    <= 1'b0;
      r_e_s2    <= 1'b0;
      r_e_d     <= 1'b0;
      r_rs_s1   <= 1'b0;
      r_rs_s2   <= 1'b0;
      r_rw_s1   <= 1'b0;
      r_rw_s2   <= 1'b0;
      r_d_s1    <= 8'h00;
      r_d_s2    <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_fill    <= w_fill_nxt;
      r_ac      <= w_ac_nxt;
      r_id      <= w_id_nxt;
      r_dcb     <= w_dcb_nxt;
      r_ovr     <= w_ovr_nxt;
      r_rd_char <= r_buf[rd_addr];
      r_e_s1    <= lcd_E;
      r_e_s2    <= r_e_s1;
      r_e_d     <= r_e_s2;
      r_rs_s1   <= lcd_RS;
      r_rs_s2   <= r_rs_s1;
      r_rw_s1   <= lcd_RW;
      r_rw_s2   <= r_rw_s1;
      r_d_s1    <= lcd_data;
      r_d_s2    <= r_d_s1;
      // Read response is frozen at the E rise so the bus stays stable for the whole strobe
      if (w_rise) begin
        r_rd_data <= r_rs_s2 ? r_buf[w_idx] : {w_busy, r_ac};
        r_drive   <= r_rw_s2;
      end else if (w_fall) begin
        r_drive <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (w_we && !reset_reset) r_buf[w_waddr] <= w_wdata;
  end

  assign lcd_data    = r_drive ? r_rd_data : 8'hzz;
  assign rd_char     = r_rd_char;
  assign cursor_addr = r_ac;
  assign disp_on     = r_dcb[2];
  assign cursor_on   = r_dcb[1];
  assign blink_on    = r_dcb[0];
  assign busy        = w_busy;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb/tb_lcd_hd44780_responder.sv - directed scoreboard bench for lcd_hd44780_responder
module tb_lcd_hd44780_responder;

  localparam int BC = 20;
  localparam int CC = 32;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic       lcd_RS, lcd_RW, lcd_E;
  wire  [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       disp_on, cursor_on, blink_on, busy, overrun;
  logic [7:0] tb_drv;
  logic       tb_en;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  always #5 clk_clk = ~clk_clk;

  // Released bus reads back as all ones
  pullup u_pu (lcd_data);
  assign lcd_data = tb_en ? tb_drv : 8'hzz;

  lcd_hd44780_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .lcd_RS(lcd_RS), .lcd_RW(lcd_RW),
    .lcd_E(lcd_E), .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char),
    .cursor_addr(cursor_addr), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .busy(busy), .overrun(overrun)
  );

  task automatic expect_val(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [7:0] obs);
    logic [7:0] e;
    string t;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_underflow: observed %h with nothing expected", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] e);
    expect_val(tag, e);
    observe(obs);
  endtask

  task automatic chk_char(input int idx, input logic [7:0] e);
    @(negedge clk_clk);
    rd_addr = 5'(idx);
    expect_val($sformatf("buf[%0d]", idx), e);
    @(negedge clk_clk);
    observe(rd_char);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 1000) begin
      @(negedge clk_clk);
      k++;
    end
    chk("wait_idle", {7'd0, busy}, 8'h00);
  endtask

  // exp_busy > 0: write must start idle; checks commit latency and busy length from the E fall
  task automatic lcd_write(input logic rs, input logic [7:0] d, input int exp_busy);
    int k;
    @(negedge clk_clk);
    lcd_RS = rs; lcd_RW = 1'b0; tb_drv = d; tb_en = 1'b1;
    repeat (2) @(negedge clk_clk);
    lcd_E = 1'b1;
    repeat (6) @(negedge clk_clk);
    lcd_E = 1'b0;
    if (exp_busy > 0) begin
      repeat (2) @(negedge clk_clk);
      chk("busy_before_commit", {7'd0, busy}, 8'h00);
      @(negedge clk_clk);
      chk("busy_at_commit", {7'd0, busy}, 8'h01);
      k = 3;
      while (busy && k < 500) begin
        @(negedge clk_clk);
        k++;
      end
      chk("busy_length", 8'(k), 8'(exp_busy));
    end else begin
      repeat (4) @(negedge clk_clk);
    end
    tb_en = 1'b0;
  endtask

  task automatic lcd_read(input logic rs, input logic [7:0] e);
    @(negedge clk_clk);
    lcd_RS = rs; lcd_RW = 1'b1; tb_en = 1'b0;
    repeat (2) @(negedge clk_clk);
    chk("bus_idle_before_read", lcd_data, 8'hFF);
    lcd_E = 1'b1;
    repeat (5) @(negedge clk_clk);
    chk(rs ? "read_data" : "read_status", lcd_data, e);
    @(negedge clk_clk);
    lcd_E = 1'b0;
    repeat (4) @(negedge clk_clk);
    chk("bus_released_after_read", lcd_data, 8'hFF);
    lcd_RW = 1'b0;
  endtask

  task automatic count_fill(input string tag);
    int k = 0;
    while (busy && k < 500) begin
      @(negedge clk_clk);
      k++;
    end
    chk(tag, 8'(k), 8'd32);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset = 1'b1; lcd_RS = 1'b0; lcd_RW = 1'b0; lcd_E = 1'b0;
    tb_drv = 8'h00; tb_en = 1'b0; rd_addr = 5'd0;
    repeat (3) @(negedge clk_clk);
    chk("rst_busy", {7'd0, busy}, 8'h01);
    chk("rst_ac", {1'b0, cursor_addr}, 8'h00);
    chk("rst_dcb", {5'd0, disp_on, cursor_on, blink_on}, 8'h00);
    chk("rst_overrun", {7'd0, overrun}, 8'h00);
    chk("rst_bus", lcd_data, 8'hFF);
    chk("rst_rd_char", rd_char, 8'h00);
    reset_reset = 1'b0;
    count_fill("fill_after_reset");
    repeat (40) @(negedge clk_clk);
    for (int i = 0; i < 32; i++) chk_char(i, 8'h20);

    lcd_write(1'b0, 8'h80, BC + 3);
    lcd_write(1'b1, 8'h41, BC + 3);
    lcd_write(1'b1, 8'h42, BC + 3);
    chk_char(0, 8'h41);
    chk_char(1, 8'h42);
    chk("ac_after_two_writes", {1'b0, cursor_addr}, 8'h02);

    lcd_write(1'b0, 8'h8F, 0); wait_idle();
    lcd_write(1'b1, 8'h5A, 0); wait_idle();
    chk_char(15, 8'h5A);
    chk("ac_wrap_0f_to_40", {1'b0, cursor_addr}, 8'h40);
    lcd_write(1'b0, 8'h04, 0); wait_idle();
    lcd_write(1'b1, 8'h59, 0); wait_idle();
    chk_char(16, 8'h59);
    chk("ac_wrap_40_to_0f", {1'b0, cursor_addr}, 8'h0F);

    lcd_write(1'b1, 8'h33, 0);
    lcd_read(1'b0, 8'h8E);
    wait_idle();
    lcd_read(1'b0, 8'h0E);
    chk_char(15, 8'h33);

    lcd_write(1'b0, 8'h06, 0); wait_idle();
    lcd_write(1'b0, 8'hC0, 0);
    lcd_write(1'b1, 8'h55, 0);
    chk("overrun_set", {7'd0, overrun}, 8'h01);
    chk("ac_unchanged_on_overrun", {1'b0, cursor_addr}, 8'h40);
    lcd_read(1'b1, 8'h59);
    wait_idle();
    chk("ac_step_after_data_read", {1'b0, cursor_addr}, 8'h41);
    chk_char(16, 8'h59);

    lcd_write(1'b0, 8'h0F, 0);
    lcd_write(1'b0, 8'h01, 0);
    wait_idle();
    chk("dcb_all_on", {5'd0, disp_on, cursor_on, blink_on}, 8'h07);
    chk("ac_after_rejected_clear", {1'b0, cursor_addr}, 8'h41);
    chk_char(0, 8'h41);
    lcd_write(1'b0, 8'h01, CC + 3);
    for (int i = 0; i < 32; i++) chk_char(i, 8'h20);
    chk("ac_after_clear", {1'b0, cursor_addr}, 8'h00);
    chk("overrun_sticky", {7'd0, overrun}, 8'h01);

    lcd_write(1'b1, 8'h61, 0); wait_idle();
    chk_char(0, 8'h61);
    @(negedge clk_clk);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    chk("rst2_busy", {7'd0, busy}, 8'h01);
    chk("rst2_overrun", {7'd0, overrun}, 8'h00);
    chk("rst2_ac", {1'b0, cursor_addr}, 8'h00);
    chk("rst2_dcb", {5'd0, disp_on, cursor_on, blink_on}, 8'h00);
    reset_reset = 1'b0;
    repeat (5) @(negedge clk_clk);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    chk("rst_mid_fill_busy", {7'd0, busy}, 8'h01);
    reset_reset = 1'b0;
    count_fill("fill_restart");
    chk_char(0, 8'h20);
    chk_char(31, 8'h20);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
